// File: rtl/ov7670_line_packer_if.sv
// Capture-side, release and SRAM write-port bundle for the OV7670 line packer.
// The packer uses the slave modport; the source of bytes and releases uses master.
interface ov7670_line_packer_if #(
    parameter int unsigned WWORD = 32,
    parameter int unsigned WP    = 8,
    parameter int unsigned WADDR = 5
);
    localparam int unsigned NL = WWORD / WP;

    logic             pix_vld;
    logic [WP-1:0]    pix_data;
    logic             pix_sof;
    logic             pix_eol;
    logic             rel_vld;
    logic             rel_bank;
    logic [WWORD-1:0] db;
    logic [WADDR-1:0] ab;
    logic [NL-1:0]    wenb;
    logic             cenb;
    logic             line_done;
    logic             line_bank;
    logic [WADDR-1:0] line_words;
    logic             ovf;

    modport master (
        output pix_vld, pix_data, pix_sof, pix_eol, rel_vld, rel_bank,
        input  db, ab, wenb, cenb, line_done, line_bank, line_words, ovf
    );

    modport slave (
        input  pix_vld, pix_data, pix_sof, pix_eol, rel_vld, rel_bank,
        output db, ab, wenb, cenb, line_done, line_bank, line_words, ovf
    );
endinterface

// File: rtl/ov7670_line_packer.sv
// Packs OV7670 bytes into SRAM words and writes them into one of two ping-pong line banks;
// downstream readers get a line_done per finished line and hand banks back via release.
module ov7670_line_packer #(
    parameter int unsigned WWORD      = 32,
    parameter int unsigned WP         = 8,
    parameter int unsigned WADDR      = 5,
    parameter int unsigned BANK_WORDS = 12
) (
    input logic                    clk,
    input logic                    rst,
    ov7670_line_packer_if.slave    bus
);
    localparam int unsigned NL = WWORD / WP;
    localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {StIdle, StArm, StFill, StDrop} state_e;

    state_e           state_q, state_d;
    logic             cur_bank_q, cur_bank_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [WADDR-1:0] word_q, word_d;
    logic [WWORD-1:0] asm_q, asm_d;
    logic [WWORD-1:0] db_q, db_d;
    logic [WADDR-1:0] ab_q, ab_d;
    logic [NL-1:0]    wenb_q, wenb_d;
    logic             cenb_q, cenb_d;
    logic             line_done_q, line_done_d;
    logic             line_bank_q, line_bank_d;
    logic [WADDR-1:0] line_words_q, line_words_d;
    logic             ovf_q, ovf_d;

    logic             accept, line_end, full_eff;
    logic [WWORD-1:0] merged;
    logic [NL-1:0]    mask;

    always_comb begin
        state_d      = state_q;
        cur_bank_d   = cur_bank_q;
        bank_full_d  = bank_full_q;
        lane_d       = lane_q;
        word_d       = word_q;
        asm_d        = asm_q;
        db_d         = db_q;
        ab_d         = ab_q;
        wenb_d       = '1;
        cenb_d       = 1'b1;
        line_done_d  = 1'b0;
        line_bank_d  = line_bank_q;
        line_words_d = line_words_q;
        ovf_d        = ovf_q;
        accept       = 1'b0;
        line_end     = 1'b0;

        merged = asm_q | (WWORD'(bus.pix_data) << (lane_q * WP));
        for (int unsigned i = 0; i < NL; i++) begin
            mask[i] = (i <= 32'(lane_q));
        end

        if (bus.rel_vld) begin
            bank_full_d[bus.rel_bank] = 1'b0;
        end
        // A release arriving with the first byte already frees the bank for that byte.
        full_eff = bank_full_q[cur_bank_q] && !(bus.rel_vld && (bus.rel_bank == cur_bank_q));

        if (bus.pix_sof) begin
            state_d = StArm;
            lane_d  = '0;
            word_d  = '0;
            asm_d   = '0;
        end else if (bus.pix_vld) begin
            case (state_q)
                StArm: begin
                    if (full_eff) begin
                        ovf_d   = 1'b1;
                        state_d = bus.pix_eol ? StArm : StDrop;
                    end else begin
                        accept  = 1'b1;
                        state_d = StFill;
                    end
                end
                StFill: begin
                    if (word_q == WADDR'(BANK_WORDS)) begin
                        ovf_d = 1'b1;
                        if (bus.pix_eol) begin
                            line_end     = 1'b1;
                            line_words_d = word_q;
                        end
                    end else begin
                        accept = 1'b1;
                    end
                end
                StDrop: begin
                    if (bus.pix_eol) begin
                        state_d = StArm;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            if (bus.pix_eol || (lane_q == LW'(NL - 1))) begin
                cenb_d = 1'b0;
                ab_d   = {cur_bank_q, word_q[WADDR-2:0]};
                db_d   = merged;
                wenb_d = ~mask;
                word_d = word_q + 1'b1;
                lane_d = '0;
                asm_d  = '0;
                if (bus.pix_eol) begin
                    line_end     = 1'b1;
                    line_words_d = word_q + 1'b1;
                end
            end else begin
                lane_d = lane_q + 1'b1;
                asm_d  = merged;
            end
        end

        // Line end beats a same-cycle release of the same bank.
        if (line_end) begin
            line_done_d              = 1'b1;
            line_bank_d              = cur_bank_q;
            bank_full_d[cur_bank_q]  = 1'b1;
            cur_bank_d               = ~cur_bank_q;
            word_d                   = '0;
            lane_d                   = '0;
            asm_d                    = '0;
            state_d                  = StArm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_bank_q   <= 1'b0;
            bank_full_q  <= 2'b00;
            lane_q       <= '0;
            word_q       <= '0;
            asm_q        <= '0;
            db_q         <= '0;
            ab_q         <= '0;
            wenb_q       <= '1;
            cenb_q       <= 1'b1;
            line_done_q  <= 1'b0;
            line_bank_q  <= 1'b0;
            line_words_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_bank_q   <= cur_bank_d;
            bank_full_q  <= bank_full_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            asm_q        <= asm_d;
            db_q         <= db_d;
            ab_q         <= ab_d;
            wenb_q       <= wenb_d;
            cenb_q       <= cenb_d;
            line_done_q  <= line_done_d;
            line_bank_q  <= line_bank_d;
            line_words_q <= line_words_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.db         = db_q;
    assign bus.ab         = ab_q;
    assign bus.wenb       = wenb_q;
    assign bus.cenb       = cenb_q;
    assign bus.line_done  = line_done_q;
    assign bus.line_bank  = line_bank_q;
    assign bus.line_words = line_words_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_ov7670_line_packer.sv
// Self-checking bench for ov7670_line_packer: directed scenarios, then random lines,
// all compared against a line-level model of bank ownership and word packing.
module tb_ov7670_line_packer;
    localparam int unsigned WWORD = 32;
    localparam int unsigned WP    = 8;
    localparam int unsigned WADDR = 5;
    localparam int unsigned BW    = 12;
    localparam int unsigned NL    = WWORD / WP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ov7670_line_packer_if #(.WWORD(WWORD), .WP(WP), .WADDR(WADDR)) bus ();

    ov7670_line_packer #(.WWORD(WWORD), .WP(WP), .WADDR(WADDR), .BANK_WORDS(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Observed/expected write entries are {ab, db, wenb}; done entries are {bank, words}.
    logic [WADDR+WWORD+NL-1:0] obs_w[$], exp_w[$];
    logic [WADDR:0]            obs_d[$], exp_d[$];
    int                        obs_wc[$], obs_dc[$];

    logic [WP-1:0] line_buf[64];
    logic [1:0]    m_full;
    logic          m_bank;
    logic          m_ovf;
    logic          m_coinc;

    always @(negedge clk) begin
        if (bus.cenb === 1'b0) begin
            obs_w.push_back({bus.ab, bus.db, bus.wenb});
            obs_wc.push_back(cyc);
        end
        if (bus.line_done === 1'b1) begin
            obs_d.push_back({bus.line_bank, bus.line_words});
            obs_dc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        obs_w.delete(); exp_w.delete(); obs_d.delete(); exp_d.delete();
        obs_wc.delete(); obs_dc.delete();
    endtask

    task automatic model_reset();
        m_full = 2'b00; m_bank = 1'b0; m_ovf = 1'b0; m_coinc = 1'b0;
    endtask

    // A complete line of n bytes ending with eol, as seen from bank ownership rules.
    task automatic model_line(input int n, input bit rel_first, input bit rel_b);
        int kept, nw;
        logic [WWORD-1:0] data;
        logic [NL-1:0]    msk;
        logic [WADDR-1:0] ab_e;
        if (rel_first) m_full[rel_b] = 1'b0;
        if (m_full[m_bank]) begin
            m_ovf = 1'b1;
            return;
        end
        kept = (n > int'(NL * BW)) ? int'(NL * BW) : n;
        if (n > kept) m_ovf = 1'b1;
        m_coinc = (n == kept);
        nw = (kept + NL - 1) / NL;
        for (int w = 0; w < nw; w++) begin
            data = '0;
            msk  = '0;
            for (int l = 0; l < int'(NL); l++) begin
                if (w * NL + l < kept) begin
                    data[l*WP +: WP] = line_buf[w*NL + l];
                    msk[l] = 1'b1;
                end
            end
            ab_e = {m_bank, (WADDR-1)'(w)};
            exp_w.push_back({ab_e, data, ~msk});
        end
        exp_d.push_back({m_bank, WADDR'(nw)});
        m_full[m_bank] = 1'b1;
        m_bank = ~m_bank;
    endtask

    task automatic send_bytes(input int n, input bit with_eol, input bit rel_first,
                              input bit rel_b, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bus.pix_vld  = 1'b1;
            bus.pix_data = line_buf[i];
            bus.pix_eol  = with_eol && (i == n - 1);
            if (i == 0 && rel_first) begin
                bus.rel_vld  = 1'b1;
                bus.rel_bank = rel_b;
            end
            tick();
            bus.rel_vld  = 1'b0;
            bus.pix_vld  = 1'b0;
            bus.pix_eol  = 1'($urandom_range(0, 1));
            bus.pix_data = WP'($urandom);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        bus.pix_eol = 1'b0;
    endtask

    task automatic line(input string tag, input int n, input bit rel_first, input bit rel_b,
                        input bit gaps);
        model_line(n, rel_first, rel_b);
        send_bytes(n, 1'b1, rel_first, rel_b, gaps);
        repeat (4) tick();
        check({tag, "_nwr"}, 64'(obs_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            check({tag, "_wr"}, 64'(obs_w[i]), 64'(exp_w[i]));
        check({tag, "_ndone"}, 64'(obs_d.size()), 64'(exp_d.size()));
        if (obs_d.size() == 1 && exp_d.size() == 1) begin
            check({tag, "_done"}, 64'(obs_d[0]), 64'(exp_d[0]));
            if (obs_wc.size() > 0)
                check({tag, "_dtime"}, 64'(obs_dc[0] == obs_wc[$]), 64'(m_coinc));
        end
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(m_ovf));
        clear_q();
    endtask

    task automatic release_bank(input bit b);
        bus.rel_vld = 1'b1; bus.rel_bank = b;
        tick();
        bus.rel_vld = 1'b0;
        m_full[b] = 1'b0;
    endtask

    task automatic sof();
        bus.pix_sof = 1'b1;
        tick();
        bus.pix_sof = 1'b0;
    endtask

    task automatic fill_buf(input int base, input bit rnd);
        for (int i = 0; i < 64; i++) line_buf[i] = rnd ? WP'($urandom) : WP'(base + i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cenb"}, 64'(bus.cenb), 64'(1));
        check({tag, "_wenb"}, 64'(bus.wenb), 64'({NL{1'b1}}));
        check({tag, "_db"}, 64'(bus.db), 64'(0));
        check({tag, "_ab"}, 64'(bus.ab), 64'(0));
        check({tag, "_ldone"}, 64'(bus.line_done), 64'(0));
        check({tag, "_lbank"}, 64'(bus.line_bank), 64'(0));
        check({tag, "_lwords"}, 64'(bus.line_words), 64'(0));
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(0));
    endtask

    initial begin
        logic [WWORD-1:0] d;
        bus.pix_vld = 1'b0; bus.pix_data = '0; bus.pix_sof = 1'b0; bus.pix_eol = 1'b0;
        bus.rel_vld = 1'b0; bus.rel_bank = 1'b0;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Bytes before any start-of-frame are ignored.
        fill_buf(8'h40, 1'b0);
        send_bytes(6, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("idle_nwr", 64'(obs_w.size()), 64'(0));
        clear_q();

        sof();
        fill_buf(8'h01, 1'b0);
        line("l1", 8, 1'b0, 1'b0, 1'b0);
        fill_buf(8'h11, 1'b0);
        line("l2", 5, 1'b0, 1'b0, 1'b0);
        fill_buf(0, 1'b1);
        line("l3_full", 10, 1'b0, 1'b0, 1'b1);
        release_bank(1'b0);
        fill_buf(0, 1'b1);
        line("l4", 7, 1'b0, 1'b0, 1'b1);
        release_bank(1'b1);
        fill_buf(0, 1'b1);
        line("l52", 52, 1'b0, 1'b0, 1'b0);

        // Start-of-frame after 6 bytes: only the completed first word is written.
        release_bank(1'b0);
        sof();
        fill_buf(0, 1'b1);
        send_bytes(6, 1'b0, 1'b0, 1'b0, 1'b0);
        sof();
        repeat (3) tick();
        check("abort_nwr", 64'(obs_w.size()), 64'(1));
        d = {line_buf[3], line_buf[2], line_buf[1], line_buf[0]};
        if (obs_w.size() > 0)
            check("abort_wr", 64'(obs_w[0]), 64'({m_bank, 4'd0, d, 4'b0000}));
        check("abort_ndone", 64'(obs_d.size()), 64'(0));
        clear_q();
        fill_buf(0, 1'b1);
        line("restart", 9, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a line.
        fill_buf(0, 1'b1);
        send_bytes(5, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        clear_q();
        model_reset();

        // Release coinciding with the first byte of a line into that bank.
        sof();
        fill_buf(0, 1'b1);
        line("c1", 4, 1'b0, 1'b0, 1'b0);
        fill_buf(0, 1'b1);
        line("c2", 6, 1'b0, 1'b0, 1'b0);
        fill_buf(0, 1'b1);
        line("relfirst", 11, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r[0]) release_bank(1'b0);
            if (r[1]) release_bank(1'b1);
            fill_buf(0, 1'b1);
            line("rnd", $urandom_range(1, 56), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
